// File: rtl/pc_sequencer_pkg.sv
// Shared types and width helpers for the program-counter sequencer and its
// return-address stack.
package pc_pkg;

  typedef enum logic [1:0] {
    SEL_SEQ = 2'd0,
    SEL_BR  = 2'd1,
    SEL_JMP = 2'd2,
    SEL_JR  = 2'd3
  } next_sel_t;

  // ras_count must represent 0..RAS_DEPTH inclusive
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Control inputs from decode/execute and PC/RAS observation outputs,
// bundled between the sequencer (slave) and whoever drives it (master).
interface pc_sequencer_if
  import pc_pkg::*;
#(
  parameter int PC_W      = 14,
  parameter int RAS_DEPTH = 4
);

  logic                          stall;
  logic                          jump;
  logic                          jal;
  logic                          jr;
  logic                          beq;
  logic                          bne;
  logic                          zero;
  logic [31:0]                   rs;
  logic [25:0]                   adress;
  logic [31:0]                   ext_immed;
  logic [PC_W-1:0]               pc;
  logic [31:0]                   pc_plus1;
  logic [PC_W-1:0]               ras_top;
  logic [cnt_w(RAS_DEPTH)-1:0]   ras_count;
  logic                          jr_mispredict;
  logic                          ras_overflow;
  logic                          ras_underflow;

  modport master (
    output stall, jump, jal, jr, beq, bne, zero, rs, adress, ext_immed,
    input  pc, pc_plus1, ras_top, ras_count, jr_mispredict,
           ras_overflow, ras_underflow
  );

  modport slave (
    input  stall, jump, jal, jr, beq, bne, zero, rs, adress, ext_immed,
    output pc, pc_plus1, ras_top, ras_count, jr_mispredict,
           ras_overflow, ras_underflow
  );

endinterface

// File: rtl/pc_sequencer_ras_stack.sv
// Circular return-address stack: push writes above the top pointer, pop
// lowers it; when full a push silently overwrites the oldest slot.
module ras_stack
  import pc_pkg::*;
#(
  parameter int PC_W      = 14,
  parameter int RAS_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  logic                        pop,
  input  logic [PC_W-1:0]             push_data,
  output logic [PC_W-1:0]             top,
  output logic [cnt_w(RAS_DEPTH)-1:0] count,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = cnt_w(RAS_DEPTH);

  logic [PC_W-1:0]  mem [RAS_DEPTH];
  logic [PTR_W-1:0] top_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             empty;
  logic             full;
  logic             do_push;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(RAS_DEPTH));
  assign wr_ptr  = top_ptr + 1'b1;
  assign do_push = push & ~pop;

  assign top       = empty ? '0 : mem[top_ptr];
  assign overflow  = do_push & full;
  assign underflow = pop & empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      top_ptr <= '0;
      count   <= '0;
    end else if (pop) begin
      if (!empty) begin
        top_ptr <= top_ptr - 1'b1;
        count   <= count - 1'b1;
      end
    end else if (push) begin
      top_ptr <= wr_ptr;
      if (!full) count <= count + 1'b1;
    end
  end

  // Storage is not reset; the count alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (!reset && do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Registered PC with next-PC selection (seq/branch/jump/jr), stall hold, and
// a return-address stack that predicts jr targets.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int              PC_W      = 14,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter int              RAS_DEPTH = 4
) (
  input logic           clk,
  input logic           reset,
  pc_sequencer_if.slave bus
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_next;
  next_sel_t       sel;
  logic [31:0]     pc_ext;
  logic [31:0]     pc_inc;
  logic [31:0]     br_sum;
  logic [31:0]     jmp_ext;
  logic            taken;
  logic            commit;
  logic            push;
  logic            pop;
  logic [PC_W-1:0] ras_top;
  logic            ras_empty;
  logic            ovf_strobe;
  logic            unf_strobe;
  logic            mispredict_q;
  logic            overflow_q;
  logic            underflow_q;
  logic            unused_ok;

  // All address arithmetic is 32-bit with pc zero-extended, then truncated.
  assign pc_ext  = 32'(pc_q);
  assign pc_inc  = pc_ext + 32'd1;
  assign br_sum  = pc_inc + bus.ext_immed;
  assign jmp_ext = 32'(bus.adress);
  assign taken   = (bus.beq & bus.zero) | (bus.bne & ~bus.zero);
  assign commit  = ~bus.stall;

  always_comb begin
    sel     = SEL_SEQ;
    pc_next = pc_inc[PC_W-1:0];
    if (bus.jr) begin
      sel     = SEL_JR;
      pc_next = bus.rs[PC_W-1:0];
    end else if (bus.jump | bus.jal) begin
      sel     = SEL_JMP;
      pc_next = jmp_ext[PC_W-1:0];
    end else if (taken) begin
      sel     = SEL_BR;
      pc_next = br_sum[PC_W-1:0];
    end
  end

  // jr beats jal in the same cycle: the stack only pops.
  assign pop  = commit & (sel == SEL_JR);
  assign push = commit & (sel == SEL_JMP) & bus.jal;

  ras_stack #(
    .PC_W      (PC_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc[PC_W-1:0]),
    .top       (ras_top),
    .count     (bus.ras_count),
    .overflow  (ovf_strobe),
    .underflow (unf_strobe)
  );

  assign ras_empty = (bus.ras_count == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      mispredict_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      if (commit) pc_q <= pc_next;
      mispredict_q <= pop & (ras_empty | (ras_top != bus.rs[PC_W-1:0]));
      overflow_q   <= overflow_q | ovf_strobe;
      underflow_q  <= underflow_q | unf_strobe;
    end
  end

  assign bus.pc            = pc_q;
  assign bus.pc_plus1      = pc_inc;
  assign bus.ras_top       = ras_top;
  assign bus.jr_mispredict = mispredict_q;
  assign bus.ras_overflow  = overflow_q;
  assign bus.ras_underflow = underflow_q;

  assign unused_ok = ^{bus.rs, bus.adress, br_sum, jmp_ext};

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Registered program-counter unit for the MIPS datapath. It holds the word-addressed PC, computes the next PC (sequential, beq/bne branch, j/jal, jr), and supports a stall hold. A return-address stack (RAS) is pushed on jal and popped on jr, and it flags jr targets that disagree with the predicted return address. It sits between instruction memory addressing and the control/ALU outputs of the decode/execute stage.

## Interface
- PC_W, 14: PC width in instruction words (2 ≤ PC_W ≤ 32)
- RESET_PC, 0: PC value loaded on reset (PC_W bits)
- RAS_DEPTH, 4: return-address stack entries (power of two, ≥ 2)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- stall  in  1  hold PC and RAS; all control inputs ignored
- jump, jal, jr  in  1 each  jump controls
- beq, bne, zero  in  1 each  branch controls and ALU zero flag
- rs  in  32  jr target register value
- adress  in  26  jump target field
- ext_immed  in  32  sign-extended branch offset
- pc  out  PC_W  current PC (registered)
- pc_plus1  out  32  zero-extended pc+1 (jal link value)
- ras_top  out  PC_W  predicted return address; 0 when the stack is empty
- ras_count  out  $clog2(RAS_DEPTH+1)  number of valid entries
- jr_mispredict  out  1  registered one-cycle pulse
- ras_overflow, ras_underflow  out  1 each  sticky error flags

## Operation
- Next-PC priority: jr → jump or jal → taken branch → sequential.
- jr target: rs[PC_W-1:0].
- jump/jal target: adress zero-extended to 32 bits, then truncated to PC_W.
- Branch taken when (beq & zero) | (bne & ~zero). Target: (pc + 1 + ext_immed)[PC_W-1:0].
- Sequential target: (pc + 1) mod 2^PC_W. PC wraps from all-ones to 0.
- All arithmetic is 32-bit two's complement with pc zero-extended. The result is truncated to PC_W bits with no overflow detection.
- RAS push on a committed jal: stores (pc+1)[PC_W-1:0].
  - If not full, count increments.
  - If full, the oldest entry is overwritten (circular), count stays RAS_DEPTH, and ras_overflow is set.
- RAS pop on a committed jr.
  - If count > 0: count decrements. jr_mispredict pulses next cycle when the popped top ≠ rs[PC_W-1:0].
  - If count == 0: count stays 0, ras_underflow is set, and jr_mispredict pulses next cycle.
- jal and jr asserted together: jr wins. The target is rs, only a pop occurs, and there is no push.
- A cycle "commits" when stall = 0 and reset = 0.
- When stall = 1: pc, the RAS, and the flags hold. jr_mispredict is 0.
- Sticky flags clear only on reset.

## Timing
- Reset values: pc = RESET_PC, ras_count = 0, ras_top = 0, jr_mispredict = 0, ras_overflow = 0, ras_underflow = 0. RAS storage contents are don't-care.
- Reset dominates stall and all controls.
- A reset asserted mid-sequence discards pending RAS contents on that edge.
- The next PC is combinational from the current pc and controls. It is loaded on the rising edge of a committing cycle, giving a 1-cycle latency from control to the pc output.
- pc_plus1 and ras_top are combinational from the registered state and are valid in the same cycle.
- jr_mispredict is asserted exactly one cycle after the committing jr edge, for one cycle.
- ras_overflow and ras_underflow assert on the same edge as the offending push or pop.
- Back-to-back jal/jr on consecutive cycles are each processed fully. There are no bubbles.

## Structure
- Shared package pc_pkg holds:
  - enum next_sel_t {SEL_SEQ, SEL_BR, SEL_JMP, SEL_JR}
  - helper constant for the ras_count width
- Sub-module ras_stack, parameterised by PC_W and RAS_DEPTH:
  - circular buffer with a top pointer and count
  - push/pop inputs with pop priority
  - outputs: top, count, overflow and underflow strobes
- pc_sequencer keeps the selection logic, PC register, mispredict register and sticky flags.

## Test plan
- Reset with RESET_PC = 0x0010, then 3 free-running cycles: pc = 0x0010, then 0x0011, 0x0012, 0x0013. Flags stay 0.
- At pc = 0x0005: beq = 1, zero = 1, ext_immed = 0xFFFFFFFD. Next pc = 0x0003. The same cycle with zero = 0 gives 0x0006. bne = 1 with zero = 0 and ext_immed = 4 gives 0x000A.
- At pc = 0x0020: jal with adress = 0x40. Result: pc = 0x0040, ras_top = 0x0021, ras_count = 1.
  - Then jr with rs = 0x21: pc = 0x0021, count = 0, no mispredict.
  - Repeating with rs = 0x30: pc = 0x0030 and jr_mispredict pulses one cycle later.
- Five jal pushes with RAS_DEPTH = 4: count saturates at 4, ras_overflow = 1, and the first link value is lost.
  - Then five jr pops: the fifth sets ras_underflow and pulses jr_mispredict.
- stall held 3 cycles while jump is asserted: pc and the RAS are unchanged. With stall = 1 and reset = 1 together, pc = RESET_PC next cycle.
- At pc = 0x3FFF (PC_W = 14), sequential step: pc = 0x0000.
  - jal + jr with rs = 0x12 in the same cycle: pc = 0x0012 and only a pop occurs.
